// File: rtl/handshake_chk_pkg.sv
// Shared definitions for the handshake constant checker.
//   chk_state_e : controller states (idle, receiving a burst, reporting status)
//   cnt_width() : width needed for a counter that must reach burst_len
package handshake_chk_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRecv   = 2'd1,
    StReport = 2'd2
  } chk_state_e;

  function automatic int unsigned cnt_width(input int unsigned burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/handshake_chk_counter.sv
// Simple up-counter with synchronous clear and increment.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   clr_i  : synchronous clear (wins over inc_i)
//   inc_i  : increment by one
//   cnt_o  : current count
module handshake_chk_counter #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/handshake_const_checker.sv
// Self-check sink: after an arm, accepts BURST_LEN tokens, counts those that differ from
// EXPECTED, then offers the mismatch count as one status token and returns to idle.
// Optional build macro HANDSHAKE_CONST_CHECKER_CAPTURE_EN adds a register holding the
// first mismatching token since the last arm; otherwise first_bad is tied to zero.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   arm                          : start request, honoured only in idle
//   ins, ins_valid, ins_ready    : input token channel (ready = in receive state)
//   outs, outs_valid, outs_ready : status channel, outs = zero-extended mismatch count
//   busy                         : receiving or reporting
//   err                          : sticky mismatch flag, cleared by the next arm
//   first_bad                    : first mismatching token (capture build only)
module handshake_const_checker
  import handshake_chk_pkg::*;
#(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]    EXPECTED   = DATA_WIDTH'(32'h000000D5),
  parameter int unsigned              BURST_LEN  = 16,
  localparam int unsigned             CNT_W      = cnt_width(BURST_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  busy,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] first_bad
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(BURST_LEN - 1);

  chk_state_e       state_q, state_d;
  logic             fire, mismatch, bad_fire, arm_start, last_tok;
  logic [CNT_W-1:0] tok_cnt, bad_cnt;
  logic             err_q, err_d;

  // ready and valid decode straight from the state register: no path from ins_valid
  assign ins_ready  = (state_q == StRecv);
  assign outs_valid = (state_q == StReport);
  assign busy       = (state_q != StIdle);

  assign fire      = ins_valid & ins_ready;
  assign mismatch  = (ins != EXPECTED);
  assign bad_fire  = fire & mismatch;
  assign arm_start = (state_q == StIdle) & arm;
  assign last_tok  = (tok_cnt == LastIdx);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (arm) state_d = StRecv;
      StRecv:   if (fire && last_tok) state_d = StReport;
      StReport: if (outs_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (arm_start) begin
      err_d = 1'b0;
    end else if (bad_fire) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

  handshake_chk_counter #(
    .Width (CNT_W)
  ) u_tok_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (arm_start),
    .inc_i (fire),
    .cnt_o (tok_cnt)
  );

  handshake_chk_counter #(
    .Width (CNT_W)
  ) u_bad_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (arm_start),
    .inc_i (bad_fire),
    .cnt_o (bad_cnt)
  );

  // bad_cnt is frozen outside receive, so it already holds steady through the report
  assign outs = DATA_WIDTH'(bad_cnt);

`ifdef HANDSHAKE_CONST_CHECKER_CAPTURE_EN
  logic [DATA_WIDTH-1:0] first_bad_q, first_bad_d;

  // err_q low means no mismatch seen since arm, so this fire is the first one
  always_comb begin
    first_bad_d = first_bad_q;
    if (arm_start) begin
      first_bad_d = '0;
    end else if (bad_fire && !err_q) begin
      first_bad_d = ins;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_bad_q <= '0;
    end else begin
      first_bad_q <= first_bad_d;
    end
  end

  assign first_bad = first_bad_q;
`else
  assign first_bad = '0;
`endif

endmodule

// File: tb/tb_handshake_const_checker.sv
module tb_handshake_const_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm, ins_valid, ins_ready, outs_valid, outs_ready, busy, err;
  logic [31:0] ins, outs, first_bad;
  logic        arm1, ins_valid1, ins_ready1, outs_valid1, outs_ready1, busy1, err1;
  logic [31:0] ins1, outs1, first_bad1;

  always #5 clk = ~clk;

  handshake_const_checker dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready),
    .busy       (busy),
    .err        (err),
    .first_bad  (first_bad)
  );

  handshake_const_checker #(
    .BURST_LEN (1)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm1),
    .ins        (ins1),
    .ins_valid  (ins_valid1),
    .ins_ready  (ins_ready1),
    .outs       (outs1),
    .outs_valid (outs_valid1),
    .outs_ready (outs_ready1),
    .busy       (busy1),
    .err        (err1),
    .first_bad  (first_bad1)
  );

  typedef struct packed {
    logic [31:0] cnt;
    logic        err;
    logic [31:0] fb;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] burst[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference: the report is the number of tokens differing from 0xD5,
  // and the captured value is the earliest such token.
  function automatic exp_t model();
    exp_t e;
    e = '0;
    foreach (burst[i]) begin
      if (burst[i] != 32'hD5) begin
        if (!e.err) e.fb = burst[i];
        e.err = 1'b1;
        e.cnt = e.cnt + 32'd1;
      end
    end
`ifndef HANDSHAKE_CONST_CHECKER_CAPTURE_EN
    e.fb = '0;
`endif
    return e;
  endfunction

  // Scoreboard monitor: compares on every completed status handshake
  always @(negedge clk) begin
    if (!rst && outs_valid && outs_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL status_unexpected: got outs=%0h, want no status token", outs);
      end else begin
        mon_e = exp_q.pop_front();
        check("status_outs", outs, mon_e.cnt);
        check("status_err", 32'(err), 32'(mon_e.err));
        check("status_first_bad", first_bad, mon_e.fb);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  // Random token: 0xD5 most of the time, otherwise an arbitrary value.
  function automatic logic [31:0] rand_tok();
    if ($urandom_range(99) < 30) return $urandom;
    return 32'hD5;
  endfunction

  task automatic arm_dut();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic send_tokens(input int gap_pct, input int nsend, input bit arm_mid,
                             output int cycles);
    logic fired;
    int   guard;
    cycles = 0;
    for (int i = 0; i < nsend; i++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        ins_valid = 1'b0;
        ins       = $urandom;
        @(posedge clk); #1;
        cycles++;
      end
      ins_valid = 1'b1;
      ins       = burst[i];
      arm       = arm_mid && (i == nsend / 2);
      fired     = 1'b0;
      guard     = 0;
      while (!fired && guard < 20) begin
        @(negedge clk);
        fired = ins_ready;
        @(posedge clk); #1;
        arm = 1'b0;
        cycles++;
        guard++;
      end
      if (!fired) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ins_ready_timeout: got ins_ready=0, want 1 for token %0d", i);
      end
    end
    ins_valid = 1'b0;
    arm       = 1'b0;
  endtask

  // Called right after the last fire; report must be visible at the next sample.
  task automatic finish_report(input int hold, input bit arm_at_done, input logic [31:0] exp_cnt);
    ins_valid = 1'b1;
    ins       = $urandom;
    if (hold > 0) outs_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_outs_valid", 32'(outs_valid), 32'd1);
      check("hold_outs", outs, exp_cnt);
      check("hold_ins_ready", 32'(ins_ready), 32'd0);
      arm = arm_at_done;
      @(posedge clk); #1;
    end
    outs_ready = 1'b1;
    arm        = arm_at_done;
    @(negedge clk);
    check("report_valid", 32'(outs_valid), 32'd1);
    @(posedge clk); #1;
    arm = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_outs_valid", 32'(outs_valid), 32'd0);
      check("idle_ins_ready", 32'(ins_ready), 32'd0);
      @(posedge clk); #1;
    end
    ins_valid = 1'b0;
  endtask

  task automatic run_burst(input int gap_pct, input bit arm_mid, input int hold,
                           input bit arm_at_done);
    exp_t e;
    int   cyc;
    e = model();
    exp_q.push_back(e);
    arm_dut();
    send_tokens(gap_pct, burst.size(), arm_mid, cyc);
    finish_report(hold, arm_at_done, e.cnt);
  endtask

  initial begin
    int          cyc;
    exp_t        e;
    logic [31:0] want_fb;
    rst = 1'b1;
    arm = 1'b0; ins = '0; ins_valid = 1'b0; outs_ready = 1'b1;
    arm1 = 1'b0; ins1 = '0; ins_valid1 = 1'b0; outs_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ins_ready", 32'(ins_ready), 32'd0);
    check("rst_outs_valid", 32'(outs_valid), 32'd0);
    check("rst_outs", outs, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_first_bad", first_bad, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: clean burst back to back
    burst.delete();
    for (int i = 0; i < 16; i++) burst.push_back(32'hD5);
    e = model();
    exp_q.push_back(e);
    arm_dut();
    send_tokens(0, 16, 1'b0, cyc);
    check("t1_b2b_cycles", 32'(cyc), 32'd16);
    finish_report(0, 1'b0, e.cnt);

    // 2: three bad tokens including the final one
    burst.delete();
    for (int i = 0; i < 16; i++) burst.push_back((i == 3 || i == 7 || i == 15) ? 32'h0 : 32'hD5);
    run_burst(0, 1'b0, 0, 1'b0);

    // 3: downstream stall for 5 cycles
    burst.delete();
    for (int i = 0; i < 16; i++) burst.push_back((i == 1 || i == 9) ? 32'h1234 + i : 32'hD5);
    run_burst(0, 1'b0, 5, 1'b0);

    // 4: arm pulses in receive, during report and on the completing cycle
    burst.delete();
    for (int i = 0; i < 16; i++) burst.push_back((i == 12) ? 32'hD4 : 32'hD5);
    run_burst(0, 1'b1, 2, 1'b1);

    // 5: asynchronous reset after 8 fires
    burst.delete();
    for (int i = 0; i < 16; i++) burst.push_back((i < 3) ? 32'h11 : 32'hD5);
    arm_dut();
    send_tokens(0, 8, 1'b0, cyc);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ins_ready", 32'(ins_ready), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_outs", outs, 32'd0);
    check("arst_outs_valid", 32'(outs_valid), 32'd0);
    check("arst_first_bad", first_bad, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    burst.delete();
    for (int i = 0; i < 16; i++) burst.push_back((i == 5 || i == 6) ? 32'hFFFF_FFFF : 32'hD5);
    run_burst(0, 1'b0, 0, 1'b0);

    // 6: single-token burst instance
    arm1 = 1'b1;
    @(posedge clk); #1;
    arm1 = 1'b0;
    ins1 = 32'hAA;
    ins_valid1 = 1'b1;
    @(negedge clk);
    check("b1_ins_ready", 32'(ins_ready1), 32'd1);
    @(posedge clk); #1;
    ins_valid1 = 1'b0;
    @(negedge clk);
`ifdef HANDSHAKE_CONST_CHECKER_CAPTURE_EN
    want_fb = 32'hAA;
`else
    want_fb = 32'h0;
`endif
    check("b1_outs_valid", 32'(outs_valid1), 32'd1);
    check("b1_outs", outs1, 32'd1);
    check("b1_err", 32'(err1), 32'd1);
    check("b1_first_bad", first_bad1, want_fb);
    @(posedge clk); #1;
    @(negedge clk);
    check("b1_idle_busy", 32'(busy1), 32'd0);
    check("b1_err_sticky", 32'(err1), 32'd1);
    @(posedge clk); #1;

    // Randomized bursts with gaps, stalls and stray arms
    for (int b = 0; b < 10; b++) begin
      burst.delete();
      for (int i = 0; i < 16; i++) burst.push_back(rand_tok());
      run_burst(25, 1'($urandom_range(1)), int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
